mon_event_arbiter: RTL and testbench

- Shares the single DPI monitor channel between up to NUM_REQ SV collectors.
- Collectors present events on valid/ready ports. The block grants one per cycle in round-robin order and loads it into a one-deep output register.
- The downstream passive interface drains that register into the C monitor.
- Each event is tagged with its source index and a global sequence number, so the C side can detect ordering or loss.

---
 rtl/mon_event_arbiter_if.sv | 38 +++
 rtl/mon_event_arbiter.sv | 125 ++++++++++++
 tb/tb_mon_event_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mon_event_arbiter_if.sv
// Requester-side and event-side handshake bundle for mon_event_arbiter.
// The evt_stamp signal is present only when MON_ARB_TIMESTAMP_EN is defined.
interface mon_event_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      evt_valid;
    logic                      evt_ready;
    logic [SRC_W-1:0]          evt_src;
    logic [DATA_W-1:0]         evt_data;
    logic [31:0]               evt_seq;
`ifdef MON_ARB_TIMESTAMP_EN
    logic [31:0]               evt_stamp;

    modport master (
        input  req_valid, req_data, evt_ready,
        output req_ready, evt_valid, evt_src, evt_data, evt_seq, evt_stamp
    );
    modport slave (
        output req_valid, req_data, evt_ready,
        input  req_ready, evt_valid, evt_src, evt_data, evt_seq, evt_stamp
    );
`else
    modport master (
        input  req_valid, req_data, evt_ready,
        output req_ready, evt_valid, evt_src, evt_data, evt_seq
    );
    modport slave (
        output req_valid, req_data, evt_ready,
        input  req_ready, evt_valid, evt_src, evt_data, evt_seq
    );
`endif
endinterface

// File: rtl/mon_event_arbiter.sv
// Round-robin arbiter sharing one monitor channel among NUM_REQ collectors, with a
// one-deep output register tagged by source and sequence number. Optional: MON_ARB_TIMESTAMP_EN.
module mon_event_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [31:0]         cycle_count,
    mon_event_arbiter_if.master bus
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  last_grant_q, last_grant_d;
    logic [SRC_W-1:0]  src_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       seq_q;
    logic [31:0]       seq_next_q, seq_next_d;
    logic [SRC_W-1:0]  winner;
    logic [DATA_W-1:0] win_data;
    logic              found;
    logic              slot_free;
    logic              grant;

    assign slot_free = (state_q == StEmpty) || bus.evt_ready;
    assign grant     = enable && slot_free && found;

    // Circular search starting one past the previous winner.
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx    = last_grant_q;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == SRC_W'(i)) win_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant && !rst) bus.req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        seq_next_d   = seq_next_q;
        if (grant) begin
            state_d      = StFull;
            last_grant_d = winner;
            seq_next_d   = seq_next_q + 32'd1;
        end else if (state_q == StFull && bus.evt_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            seq_next_q   <= '0;
            src_q        <= '0;
            data_q       <= '0;
            seq_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            seq_next_q   <= seq_next_d;
            if (grant) begin
                src_q  <= winner;
                data_q <= win_data;
                seq_q  <= seq_next_q;
            end
        end
    end

    assign bus.evt_valid = (state_q == StFull);
    assign bus.evt_src   = src_q;
    assign bus.evt_data  = data_q;
    assign bus.evt_seq   = seq_q;

`ifdef MON_ARB_TIMESTAMP_EN
    logic [31:0] stamp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        stamp_q <= '0;
        else if (grant) stamp_q <= cycle_count;
    end

    assign bus.evt_stamp = stamp_q;
`else
    logic unused_cycle_count;
    assign unused_cycle_count = ^cycle_count;
`endif

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));
    a_ready_implies_valid : assert property (@(posedge clk) disable iff (rst)
        (bus.req_ready & ~bus.req_valid) == '0);
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (bus.evt_valid && !bus.evt_ready) |=>
            ($stable(bus.evt_src) && $stable(bus.evt_data) && $stable(bus.evt_seq)));
`ifdef MON_ARB_TIMESTAMP_EN
    a_hold_stamp : assert property (@(posedge clk) disable iff (rst)
        (bus.evt_valid && !bus.evt_ready) |=> $stable(bus.evt_stamp));
`endif
`endif

endmodule

// File: tb/tb_mon_event_arbiter.sv
// Self-checking bench for mon_event_arbiter: directed scenarios plus a randomized run
// against a queue-free behavioural model of the round-robin rules.
module tb_mon_event_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] cycle_count;
    int          checks = 0;
    int          errors = 0;

    logic [DATA_W-1:0] data_arr [NUM_REQ];

    mon_event_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    mon_event_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cycle_count (cycle_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = data_arr[i];
    end

    // Reference model of the output register and arbitration pointer.
    bit          m_valid;
    int          m_src;
    logic [31:0] m_data, m_seq, m_stamp, m_seq_next;
    int          m_last;
    int          last_win;

    function automatic void model_reset();
        m_valid = 0; m_src = 0; m_data = '0; m_seq = '0; m_stamp = '0;
        m_seq_next = '0; m_last = NUM_REQ - 1;
    endfunction

    function automatic int model_winner();
        if (!enable || (m_valid && !bus.evt_ready)) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (m_last + k) % NUM_REQ;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_ready();
        logic [NUM_REQ-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // One clock: model follows the edge, returns at the next falling edge.
    task automatic tick();
        int w;
        w = model_winner();
        @(posedge clk);
        if (w >= 0) begin
            m_valid = 1; m_src = w; m_data = data_arr[w]; m_seq = m_seq_next;
            m_seq_next = m_seq_next + 32'd1; m_last = w; m_stamp = cycle_count;
        end else if (bus.evt_ready) begin
            m_valid = 0;
        end
        last_win = w;
        @(negedge clk);
        cycle_count = cycle_count + 32'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; cycle_count = '0;
        bus.req_valid = '1; bus.evt_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) data_arr[i] = $urandom;
        repeat (2) @(negedge clk);
        checks += 5;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.evt_valid); end
        if (bus.evt_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", bus.evt_src); end
        if (bus.evt_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.evt_data); end
        if (bus.evt_seq !== 32'd0) begin errors++; $display("FAIL reset_seq got %h want 0", bus.evt_seq); end
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        #1;
        checks += 2;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b want 0001", bus.req_ready); end
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL rr_pre_valid got %b want 0", bus.evt_valid); end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks += 4;
            if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b want 1", n, bus.evt_valid); end
            if (bus.evt_src !== 2'(n % NUM_REQ)) begin errors++; $display("FAIL rr_src[%0d] got %0d want %0d", n, bus.evt_src, n % NUM_REQ); end
            if (bus.evt_seq !== 32'(n)) begin errors++; $display("FAIL rr_seq[%0d] got %0d want %0d", n, bus.evt_seq, n); end
            if (bus.evt_data !== m_data) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", n, bus.evt_data, m_data); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        data_arr[2] = 32'hDEAD_BEEF;
        bus.req_valid = 4'b0100; bus.evt_ready = 1'b0;
        tick();
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", n, bus.req_ready); end
            tick();
            checks += 4;
            if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", n, bus.evt_valid); end
            if (bus.evt_src !== 2'd2) begin errors++; $display("FAIL bp_src[%0d] got %0d want 2", n, bus.evt_src); end
            if (bus.evt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_data[%0d] got %h want deadbeef", n, bus.evt_data); end
            if (bus.evt_seq !== 32'd0) begin errors++; $display("FAIL bp_seq[%0d] got %0d want 0", n, bus.evt_seq); end
        end
        bus.evt_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b want 1000", bus.req_ready); end
        tick();
        checks += 2;
        if (bus.evt_src !== 2'd3) begin errors++; $display("FAIL bp_next_src got %0d want 3", bus.evt_src); end
        if (bus.evt_seq !== 32'd1) begin errors++; $display("FAIL bp_next_seq got %0d want 1", bus.evt_seq); end
    endtask

    task automatic test_sparse();
        bus.req_valid = 4'b0010; bus.evt_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks += 2;
            if (bus.evt_src !== 2'd1) begin errors++; $display("FAIL sparse_src[%0d] got %0d want 1", n, bus.evt_src); end
            if (bus.evt_seq !== 32'(2 + n)) begin errors++; $display("FAIL sparse_seq[%0d] got %0d want %0d", n, bus.evt_seq, 2 + n); end
        end
        bus.req_valid = 4'b1001;
        tick();
        checks++;
        if (bus.evt_src !== 2'd3) begin errors++; $display("FAIL sparse_pair_first got %0d want 3", bus.evt_src); end
        bus.req_valid = 4'b0001;
        tick();
        checks += 2;
        if (bus.evt_src !== 2'd0) begin errors++; $display("FAIL sparse_pair_second got %0d want 0", bus.evt_src); end
        if (bus.evt_seq !== 32'd6) begin errors++; $display("FAIL sparse_pair_seq got %0d want 6", bus.evt_seq); end
    endtask

    task automatic test_enable();
        bus.req_valid = 4'b1111; bus.evt_ready = 1'b1;
        tick();
        enable = 1'b0;
        #1;
        checks += 2;
        if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL en_held_valid got %b want 1", bus.evt_valid); end
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL en_off_ready got %b want 0000", bus.req_ready); end
        for (int n = 0; n < 4; n++) begin
            tick();
            #1;
            checks += 2;
            if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL en_drain_valid[%0d] got %b want 0", n, bus.evt_valid); end
            if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL en_idle_ready[%0d] got %b want 0000", n, bus.req_ready); end
        end
        enable = 1'b1;
        tick();
        checks += 3;
        if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL en_resume_valid got %b want 1", bus.evt_valid); end
        if (bus.evt_seq !== 32'd8) begin errors++; $display("FAIL en_resume_seq got %0d want 8", bus.evt_seq); end
        if (bus.evt_src !== 2'(m_src)) begin errors++; $display("FAIL en_resume_src got %0d want %0d", bus.evt_src, m_src); end
    endtask

    task automatic test_wrap_reset();
        enable = 1'b0; bus.evt_ready = 1'b1;
        tick();
        force dut.seq_next_q = 32'hFFFF_FFFE;
        #1;
        release dut.seq_next_q;
        m_seq_next = 32'hFFFF_FFFE;
        enable = 1'b1; bus.req_valid = 4'b1111;
        tick();
        checks++;
        if (bus.evt_seq !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_seq0 got %h want fffffffe", bus.evt_seq); end
        tick();
        checks++;
        if (bus.evt_seq !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_seq1 got %h want ffffffff", bus.evt_seq); end
        tick();
        checks++;
        if (bus.evt_seq !== 32'h0000_0000) begin errors++; $display("FAIL wrap_seq2 got %h want 00000000", bus.evt_seq); end
        bus.evt_ready = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", bus.evt_valid); end
        if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_async_ready got %b want 0000", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.evt_ready = 1'b1;
        tick();
        checks += 2;
        if (bus.evt_src !== 2'd0) begin errors++; $display("FAIL rst_first_src got %0d want 0", bus.evt_src); end
        if (bus.evt_seq !== 32'd0) begin errors++; $display("FAIL rst_first_seq got %0d want 0", bus.evt_seq); end
    endtask

`ifdef MON_ARB_TIMESTAMP_EN
    task automatic test_stamp();
        enable = 1'b1; bus.req_valid = 4'b0000; bus.evt_ready = 1'b1;
        tick();
        bus.req_valid = 4'b0001;
        cycle_count = 32'd100;
        tick();
        bus.req_valid = 4'b0000; bus.evt_ready = 1'b0;
        checks++;
        if (bus.evt_stamp !== 32'd100) begin errors++; $display("FAIL stamp_load got %0d want 100", bus.evt_stamp); end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (bus.evt_stamp !== 32'd100) begin errors++; $display("FAIL stamp_hold[%0d] got %0d want 100", n, bus.evt_stamp); end
        end
        bus.evt_ready = 1'b1;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] exp_ready;
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    data_arr[i] = $urandom;
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            bus.req_valid = pend;
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            #1;
            exp_ready = model_ready();
            checks++;
            if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", n, bus.req_ready, exp_ready); end
            tick();
            if (last_win >= 0) pend[last_win] = 1'b0;
            checks++;
            if (bus.evt_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b want %b", n, bus.evt_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (bus.evt_src !== 2'(m_src) || bus.evt_data !== m_data || bus.evt_seq !== m_seq) begin
                    errors++;
                    $display("FAIL rand_event[%0d] got src=%0d data=%h seq=%0d want src=%0d data=%h seq=%0d",
                             n, bus.evt_src, bus.evt_data, bus.evt_seq, m_src, m_data, m_seq);
                end
`ifdef MON_ARB_TIMESTAMP_EN
                checks++;
                if (bus.evt_stamp !== m_stamp) begin errors++; $display("FAIL rand_stamp[%0d] got %0d want %0d", n, bus.evt_stamp, m_stamp); end
`endif
            end
        end
    endtask

    initial begin
        model_reset();
        last_win = -1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_enable();
        test_wrap_reset();
`ifdef MON_ARB_TIMESTAMP_EN
        test_stamp();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
